// File: rtl/mem_access_stage.sv
// Memory-access stage after the ALU: byte/half/word loads and stores over a req/ack data bus,
// load alignment/extension, non-memory pass-through and address/bus-timeout exceptions.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_q,
    input  logic [31:0] st_data,
    input  logic        op_lb,
    input  logic        op_lbu,
    input  logic        op_lh,
    input  logic        op_lhu,
    input  logic        op_lw,
    input  logic        op_sb,
    input  logic        op_sh,
    input  logic        op_sw,
    input  logic [4:0]  rd_in,
    input  logic        wreg_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic [31:0] bad_addr
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;
    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_adel_q, exc_adel_d;
    logic        exc_ades_q, exc_ades_d;
    logic        exc_bus_q, exc_bus_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic        wreg_q, wreg_d;
    logic [4:0]  rd_q, rd_d;

    logic        accept;
    logic        is_load, is_store, sext, misalign;
    logic [1:0]  size;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rshift;
    logic [31:0] load_val;
    logic [15:0] half_sel;

    // In-ready is forced low while reset is held so every output reads 0 during reset.
    assign in_ready = (state_q == StIdle) && !rst;
    assign accept   = in_valid && in_ready;

    // Priority decode: lw > lh > lhu > lb > lbu > sw > sh > sb.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SzWord;
        sext     = 1'b0;
        if (op_lw) begin
            is_load = 1'b1;
        end else if (op_lh) begin
            is_load = 1'b1; size = SzHalf; sext = 1'b1;
        end else if (op_lhu) begin
            is_load = 1'b1; size = SzHalf;
        end else if (op_lb) begin
            is_load = 1'b1; size = SzByte; sext = 1'b1;
        end else if (op_lbu) begin
            is_load = 1'b1; size = SzByte;
        end else if (op_sw) begin
            is_store = 1'b1;
        end else if (op_sh) begin
            is_store = 1'b1; size = SzHalf;
        end else if (op_sb) begin
            is_store = 1'b1; size = SzByte;
        end
    end

    always_comb begin
        misalign   = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = st_data;
        case (size)
            SzByte: begin
                be_calc    = 4'b0001 << alu_q[1:0];
                wdata_calc = {4{st_data[7:0]}};
            end
            SzHalf: begin
                misalign   = alu_q[0];
                be_calc    = 4'b0011 << {alu_q[1], 1'b0};
                wdata_calc = {2{st_data[15:0]}};
            end
            default: misalign = (alu_q[1:0] != 2'b00);
        endcase
    end

    // Little-endian lane select, using the latched byte offset of the request.
    always_comb begin
        rshift   = mem_rdata >> {fault_addr_q[1:0], 3'b000};
        half_sel = fault_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SzByte:  load_val = {{24{rshift[7] & sext_q}}, rshift[7:0]};
            SzHalf:  load_val = {{16{half_sel[15] & sext_q}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        exc_adel_d   = 1'b0;
        exc_ades_d   = 1'b0;
        exc_bus_d    = 1'b0;
        bad_addr_d   = bad_addr_q;
        fault_addr_d = fault_addr_q;
        size_d       = size_q;
        sext_d       = sext_q;
        wreg_d       = wreg_q;
        rd_d         = rd_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!is_load && !is_store) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = wreg_in;
                        wb_rd_d    = rd_in;
                        wb_data_d  = alu_q;
                    end else if (misalign) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_in;
                        wb_data_d  = '0;
                        exc_adel_d = is_load;
                        exc_ades_d = is_store;
                        bad_addr_d = alu_q;
                    end else begin
                        state_d      = StWait;
                        cnt_d        = '0;
                        mem_req_d    = 1'b1;
                        mem_we_d     = is_store;
                        mem_be_d     = be_calc;
                        mem_addr_d   = {alu_q[31:2], 2'b00};
                        mem_wdata_d  = wdata_calc;
                        fault_addr_d = alu_q;
                        size_d       = size;
                        sext_d       = sext;
                        wreg_d       = wreg_in;
                        rd_d         = rd_in;
                    end
                end
            end
            StWait: begin
                if (mem_ack) begin
                    state_d    = StIdle;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = !mem_we_q && wreg_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = mem_we_q ? '0 : load_val;
                end else if (cnt_q == CntLast) begin
                    state_d    = StIdle;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = '0;
                    exc_bus_d  = 1'b1;
                    bad_addr_d = fault_addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            exc_adel_q   <= 1'b0;
            exc_ades_q   <= 1'b0;
            exc_bus_q    <= 1'b0;
            bad_addr_q   <= '0;
            fault_addr_q <= '0;
            size_q       <= SzWord;
            sext_q       <= 1'b0;
            wreg_q       <= 1'b0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            exc_adel_q   <= exc_adel_d;
            exc_ades_q   <= exc_ades_d;
            exc_bus_q    <= exc_bus_d;
            bad_addr_q   <= bad_addr_d;
            fault_addr_q <= fault_addr_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            wreg_q       <= wreg_d;
            rd_q         <= rd_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_adel  = exc_adel_q;
    assign exc_ades  = exc_ades_q;
    assign exc_bus   = exc_bus_q;
    assign bad_addr  = bad_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single ops plus hand-written
// sequences for reset, back-to-back pass-through, ack-when-idle and bus timeout.
module tb_mem_access_stage;

    localparam logic [7:0] OP_NONE = 8'h00;
    localparam logic [7:0] OP_LW   = 8'h80;
    localparam logic [7:0] OP_LH   = 8'h40;
    localparam logic [7:0] OP_LHU  = 8'h20;
    localparam logic [7:0] OP_LB   = 8'h10;
    localparam logic [7:0] OP_LBU  = 8'h08;
    localparam logic [7:0] OP_SW   = 8'h04;
    localparam logic [7:0] OP_SH   = 8'h02;
    localparam logic [7:0] OP_SB   = 8'h01;

    logic        clk, rst, in_valid, in_ready;
    logic [31:0] alu_q, st_data;
    logic [7:0]  ops;
    logic [4:0]  rd_in;
    logic        wreg_in;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid, wb_we, exc_adel, exc_ades, exc_bus;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, bad_addr;

    int errs   = 0;
    int checks = 0;

    mem_access_stage #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_q     (alu_q),
        .st_data   (st_data),
        .op_lb     (ops[4]),
        .op_lbu    (ops[3]),
        .op_lh     (ops[6]),
        .op_lhu    (ops[5]),
        .op_lw     (ops[7]),
        .op_sb     (ops[0]),
        .op_sh     (ops[1]),
        .op_sw     (ops[2]),
        .rd_in     (rd_in),
        .wreg_in   (wreg_in),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .exc_bus   (exc_bus),
        .bad_addr  (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  ops;
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] rdata;
        int          delay;
        logic        is_mem;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_wbwe;
        logic        chk_data;
        logic [31:0] e_data;
        logic        e_adel;
        logic        e_ades;
    } vec_t;

    vec_t vecs[15];

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        ops = v.ops; alu_q = v.alu; st_data = v.st; rd_in = v.rd; wreg_in = v.wreg;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ops = OP_NONE;
        if (v.is_mem) begin
            chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
            chk({tag, " mem_addr"}, mem_addr, v.e_addr);
            chk({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, v.e_be});
            chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, v.e_we});
            if (v.e_we) chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
            repeat (v.delay) @(negedge clk);
            chk({tag, " req_held"}, {31'd0, mem_req}, 32'd1);
            mem_ack = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_ack = 1'b0;
            chk({tag, " req_drop"}, {31'd0, mem_req}, 32'd0);
        end else begin
            chk({tag, " no_req"}, {31'd0, mem_req}, 32'd0);
            if (v.e_adel || v.e_ades) chk({tag, " bad_addr"}, bad_addr, v.alu);
        end
        chk({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, " wb_we"}, {31'd0, wb_we}, {31'd0, v.e_wbwe});
        chk({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
        chk({tag, " exc_adel"}, {31'd0, exc_adel}, {31'd0, v.e_adel});
        chk({tag, " exc_ades"}, {31'd0, exc_ades}, {31'd0, v.e_ades});
        chk({tag, " exc_bus"}, {31'd0, exc_bus}, 32'd0);
        if (v.chk_data) chk({tag, " wb_data"}, wb_data, v.e_data);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; alu_q = '0; st_data = '0; ops = OP_NONE;
        rd_in = '0; wreg_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        //          ops      alu           st            rd  wr rdata         dly mem addr          be       we wdata         wbwe cd data          adel ades
        vecs[0]  = '{OP_LB,  32'h0000_0103, 32'h0,        5'd5, 1, 32'h80FF_0000, 2, 1, 32'h0000_0100, 4'b1000, 0, 32'h0,        1, 1, 32'hFFFF_FF80, 0, 0};
        vecs[1]  = '{OP_LBU, 32'h0000_0103, 32'h0,        5'd6, 1, 32'h80FF_0000, 2, 1, 32'h0000_0100, 4'b1000, 0, 32'h0,        1, 1, 32'h0000_0080, 0, 0};
        vecs[2]  = '{OP_SH,  32'h0000_0202, 32'h1234_ABCD, 5'd7, 1, 32'h0,        1, 1, 32'h0000_0200, 4'b1100, 1, 32'hABCD_ABCD, 0, 0, 32'h0,        0, 0};
        vecs[3]  = '{OP_LW,  32'h0000_0006, 32'h0,        5'd8, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 0, 32'h0,        0, 0, 32'h0,        1, 0};
        vecs[4]  = '{OP_SW,  32'h0000_0005, 32'h0,        5'd9, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 0, 32'h0,        0, 0, 32'h0,        0, 1};
        vecs[5]  = '{OP_LH,  32'h0000_0102, 32'h0,        5'd10, 1, 32'h8001_7FFF, 0, 1, 32'h0000_0100, 4'b1100, 0, 32'h0,       1, 1, 32'hFFFF_8001, 0, 0};
        vecs[6]  = '{OP_LHU, 32'h0000_0102, 32'h0,        5'd11, 1, 32'h8001_7FFF, 0, 1, 32'h0000_0100, 4'b1100, 0, 32'h0,       1, 1, 32'h0000_8001, 0, 0};
        vecs[7]  = '{OP_LW,  32'h0000_0200, 32'h0,        5'd12, 1, 32'hDEAD_BEEF, 1, 1, 32'h0000_0200, 4'b1111, 0, 32'h0,       1, 1, 32'hDEAD_BEEF, 0, 0};
        vecs[8]  = '{OP_SB,  32'h0000_0301, 32'h0000_00A5, 5'd13, 1, 32'h0,       0, 1, 32'h0000_0300, 4'b0010, 1, 32'hA5A5_A5A5, 0, 0, 32'h0,       0, 0};
        vecs[9]  = '{OP_SW,  32'h0000_0400, 32'hCAFE_F00D, 5'd14, 1, 32'h0,       2, 1, 32'h0000_0400, 4'b1111, 1, 32'hCAFE_F00D, 0, 0, 32'h0,       0, 0};
        vecs[10] = '{OP_LH,  32'h0000_0101, 32'h0,        5'd15, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 0, 32'h0,        0, 0, 32'h0,        1, 0};
        vecs[11] = '{OP_NONE, 32'h0000_1234, 32'h0,       5'd16, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 0, 32'h0,        1, 1, 32'h0000_1234, 0, 0};
        vecs[12] = '{OP_LB,  32'h0000_0102, 32'h0,        5'd17, 0, 32'h007F_0000, 0, 1, 32'h0000_0100, 4'b0100, 0, 32'h0,       0, 1, 32'h0000_007F, 0, 0};
        vecs[13] = '{OP_LW | OP_SB, 32'h0000_0003, 32'h0, 5'd18, 1, 32'h0,        0, 0, 32'h0,        4'b0000, 0, 32'h0,        0, 0, 32'h0,        1, 0};
        // Ack arriving in the last cycle before timeout must complete normally.
        vecs[14] = '{OP_LW,  32'h0000_0204, 32'h0,        5'd19, 1, 32'h1234_5678, 3, 1, 32'h0000_0204, 4'b1111, 0, 32'h0,       1, 1, 32'h1234_5678, 0, 0};

        #1 rst = 1'b1;
        #1;
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Back-to-back pass-through.
        @(negedge clk);
        ops = OP_NONE; wreg_in = 1'b1; rd_in = 5'd3; in_valid = 1'b1; alu_q = 32'd1;
        @(negedge clk);
        chk("pt1 wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("pt1 wb_data", wb_data, 32'd1);
        alu_q = 32'd2;
        @(negedge clk);
        chk("pt2 wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("pt2 wb_data", wb_data, 32'd2);
        alu_q = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pt3 wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("pt3 wb_data", wb_data, 32'd3);
        @(negedge clk);
        chk("pt idle wb_valid", {31'd0, wb_valid}, 32'd0);

        // Stray ack while idle is ignored.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle ack wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("idle ack mem_req", {31'd0, mem_req}, 32'd0);

        // Bus timeout with TIMEOUT_CYC=4.
        ops = OP_LW; alu_q = 32'h0000_0040; rd_in = 5'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; ops = OP_NONE;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to wait%0d mem_req", c), {31'd0, mem_req}, 32'd1);
            chk($sformatf("to wait%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("to wait%0d exc_bus", c), {31'd0, exc_bus}, 32'd0);
            @(negedge clk);
        end
        chk("to exc_bus", {31'd0, exc_bus}, 32'd1);
        chk("to mem_req", {31'd0, mem_req}, 32'd0);
        chk("to in_ready", {31'd0, in_ready}, 32'd1);
        chk("to wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("to wb_we", {31'd0, wb_we}, 32'd0);
        chk("to bad_addr", bad_addr, 32'h0000_0040);
        @(negedge clk);
        chk("to pulse end", {31'd0, exc_bus}, 32'd0);

        // Reset in the middle of a WAIT.
        ops = OP_LW; alu_q = 32'h0000_0100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; ops = OP_NONE;
        chk("rw mem_req before", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rw mem_req", {31'd0, mem_req}, 32'd0);
        chk("rw mem_addr", mem_addr, 32'd0);
        chk("rw mem_be", {28'd0, mem_be}, 32'd0);
        chk("rw bad_addr", bad_addr, 32'd0);
        chk("rw in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rw in_ready after", {31'd0, in_ready}, 32'd1);
        chk("rw mem_req after", {31'd0, mem_req}, 32'd0);
        chk("rw wb_valid after", {31'd0, wb_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
